// File: rtl/alu_multicycle.sv
// alu_multicycle: registered ALU with valid/ready handshakes on both sides.
//
// Single-cycle ops (ADD..NOR, and DIVU/REMU by zero) produce a result one cycle after
// acceptance. MUL/MULHU run an iterative shift-add multiply, DIVU/REMU an iterative
// restoring divide; both take WIDTH steps, so the result appears WIDTH+1 cycles after
// acceptance.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operation handshake; ALUopcode, rega, regb captured on transfer
//   ALUopcode             operation select (0..F)
//   rega, regb            operands (rega = shift amount / dividend, regb = shifted value / divisor)
//   out_valid / out_ready result handshake
//   result                registered result
//   zero, sign            derived from the registered result
//   overflow              signed overflow of ADD/SUB, 0 otherwise
//   div0                  DIVU/REMU by zero, 0 otherwise
module alu_multicycle #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUopcode,
    input  logic [WIDTH-1:0] rega,
    input  logic [WIDTH-1:0] regb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             sign,
    output logic             overflow,
    output logic             div0
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ShiftLim = WIDTH'(WIDTH);
    localparam logic [CW-1:0] LastStep = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               overflow_q, overflow_d;
    logic               div0_q, div0_d;
    // Shared iteration register: {accumulator, multiplier} for MUL, {remainder, quotient} for DIV.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Multiplicand for MUL, divisor for DIV.
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    // Selects the upper half of acc at completion (MULHU high product, REMU remainder).
    logic               hi_q, hi_d;
    logic [CW-1:0]      count_q, count_d;

    logic accept;
    logic last_step;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] add_res, sub_res, sc_res;
    logic             sc_ovf, sc_div0;
    logic             shift_big, b_zero, lt_u, lt_s;

    always_comb begin
        add_res   = rega + regb;
        sub_res   = rega - regb;
        shift_big = (rega >= ShiftLim);
        b_zero    = (regb == '0);
        lt_u      = (rega < regb);
        lt_s      = ($signed(rega) < $signed(regb));
        sc_res    = '0;
        sc_ovf    = 1'b0;
        sc_div0   = 1'b0;
        case (ALUopcode)
            4'h0: begin
                sc_res = add_res;
                sc_ovf = (rega[WIDTH-1] == regb[WIDTH-1]) && (add_res[WIDTH-1] != rega[WIDTH-1]);
            end
            4'h1: begin
                sc_res = sub_res;
                sc_ovf = (rega[WIDTH-1] != regb[WIDTH-1]) && (sub_res[WIDTH-1] != rega[WIDTH-1]);
            end
            4'h2: sc_res = shift_big ? '0 : (regb << rega);
            4'h3: sc_res = rega | regb;
            4'h4: sc_res = rega & regb;
            4'h5: sc_res = {{(WIDTH-1){1'b0}}, lt_u};
            4'h6: sc_res = {{(WIDTH-1){1'b0}}, lt_s};
            4'h7: sc_res = regb;
            4'h8: sc_res = rega ^ regb;
            4'h9: sc_res = shift_big ? '0 : (regb >> rega);
            4'hA: sc_res = shift_big ? {WIDTH{regb[WIDTH-1]}} : WIDTH'($signed(regb) >>> rega);
            4'hB: sc_res = ~(rega | regb);
            // MUL/MULHU never take this path; DIVU/REMU only when dividing by zero.
            4'hC: sc_res = '0;
            4'hD: sc_res = '0;
            4'hE: begin
                sc_res  = '1;
                sc_div0 = 1'b1;
            end
            4'hF: begin
                sc_res  = rega;
                sc_div0 = 1'b1;
            end
            default: sc_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Iterative step logic
    // ------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        // Add multiplicand into the upper half when the current multiplier bit is set,
        // then shift the whole product right by one (carry lands in the MSB).
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        // Shift the next dividend bit into the remainder and trial-subtract the divisor.
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_diff  = div_shift - {1'b0, opnd_q};
        div_next  = div_ge ? {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                           : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    assign accept    = in_valid && in_ready;
    assign last_step = (count_q == LastStep);

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        div0_d     = div0_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        count_d    = count_q;

        unique case (state_q)
            StIdle: ;
            StMul: begin
                acc_d   = mul_next;
                count_d = count_q + CW'(1);
                if (last_step) begin
                    state_d    = StDone;
                    result_d   = hi_q ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0];
                    overflow_d = 1'b0;
                    div0_d     = 1'b0;
                end
            end
            StDiv: begin
                acc_d   = div_next;
                count_d = count_q + CW'(1);
                if (last_step) begin
                    state_d    = StDone;
                    result_d   = hi_q ? div_next[2*WIDTH-1:WIDTH] : div_next[WIDTH-1:0];
                    overflow_d = 1'b0;
                    div0_d     = 1'b0;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Acceptance is only possible in StIdle or in StDone with out_ready, so it
        // overrides whatever the case above decided.
        if (accept) begin
            count_d = '0;
            hi_d    = ALUopcode[0];
            if (ALUopcode == 4'hC || ALUopcode == 4'hD) begin
                state_d = StMul;
                acc_d   = {{WIDTH{1'b0}}, regb};
                opnd_d  = rega;
            end else if ((ALUopcode == 4'hE || ALUopcode == 4'hF) && !b_zero) begin
                state_d = StDiv;
                acc_d   = {{WIDTH{1'b0}}, rega};
                opnd_d  = regb;
            end else begin
                state_d    = StDone;
                result_d   = sc_res;
                overflow_d = sc_ovf;
                div0_d     = sc_div0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            result_q   <= '0;
            overflow_q <= 1'b0;
            div0_q     <= 1'b0;
            acc_q      <= '0;
            opnd_q     <= '0;
            hi_q       <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            div0_q     <= div0_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            count_q    <= count_d;
        end
    end

    assign out_valid = (state_q == StDone);
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign sign      = result_q[WIDTH-1];
    assign overflow  = overflow_q;
    assign div0      = div0_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=16) using a scoreboard queue.
module tb_alu_multicycle;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'h0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero, sign, overflow, div0;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ALUopcode (op),
        .rega      (a),
        .regb      (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .sign      (sign),
        .overflow  (overflow),
        .div0      (div0)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic [W-1:0] res;
        logic         z, s, o, d;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   streak = 0;
    bit   rnd_mode = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model, computed with wide integer arithmetic.
    function automatic exp_t model(input string tag, input logic [3:0] o,
                                   input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        int          sx, sy, t, sh;
        logic [31:0] p;
        e.tag = tag;
        e.o   = 1'b0;
        e.d   = 1'b0;
        e.res = '0;
        sx    = int'($signed(x));
        sy    = int'($signed(y));
        sh    = (int'(x) >= W) ? W : int'(x);
        p     = {16'h0, x} * {16'h0, y};
        case (o)
            4'h0: begin t = sx + sy; e.res = x + y; e.o = (t > 32767) || (t < -32768); end
            4'h1: begin t = sx - sy; e.res = x - y; e.o = (t > 32767) || (t < -32768); end
            4'h2: e.res = (sh >= W) ? 16'h0 : (y << sh);
            4'h3: e.res = x | y;
            4'h4: e.res = x & y;
            4'h5: e.res = (x < y) ? 16'h1 : 16'h0;
            4'h6: e.res = (sx < sy) ? 16'h1 : 16'h0;
            4'h7: e.res = y;
            4'h8: e.res = x ^ y;
            4'h9: e.res = (sh >= W) ? 16'h0 : (y >> sh);
            4'hA: begin t = sy >>> sh; e.res = t[W-1:0]; end
            4'hB: e.res = ~(x | y);
            4'hC: e.res = p[15:0];
            4'hD: e.res = p[31:16];
            4'hE: if (y == 0) begin e.res = 16'hFFFF; e.d = 1'b1; end else e.res = x / y;
            default: if (y == 0) begin e.res = x; e.d = 1'b1; end else e.res = x % y;
        endcase
        e.z = (e.res == 0);
        e.s = e.res[W-1];
        return e;
    endfunction

    // Output monitor: every result transfer is matched against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            streak++;
            if (sb.size() == 0) begin
                check_val("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_val({e.tag, "_res"}, 32'(result), 32'(e.res));
                check_val({e.tag, "_flags"}, {28'h0, zero, sign, overflow, div0},
                          {28'h0, e.z, e.s, e.o, e.d});
            end
        end else begin
            streak = 0;
        end
    end

    // Random backpressure during the random phase.
    always @(posedge clk) begin
        #1;
        if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Drive one op (called at posedge+1) and hold it until accepted; returns at posedge+1.
    task automatic issue(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit push, output int waits);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        waits = 0;
        do begin
            @(negedge clk);
            waits++;
        end while (!in_ready && waits < 200);
        if (!in_ready) check_val({tag, "_accept_timeout"}, 32'd0, 32'd1);
        else if (push) sb.push_back(model(tag, o, x, y));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = 4'($urandom);
        a = W'($urandom);
        b = W'($urandom);
    endtask

    // Count negedges until out_valid; flags any in_ready seen while busy.
    task automatic wait_out(output int n, output bit busy_ready);
        n = 0;
        busy_ready = 1'b0;
        do begin
            @(negedge clk);
            n++;
            if (!out_valid && in_ready) busy_ready = 1'b1;
        end while (!out_valid && n < 100);
    endtask

    task automatic lat_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int exp_lat);
        int w, n;
        bit busy;
        issue(tag, o, x, y, 1'b1, w);
        wait_out(n, busy);
        check_val({tag, "_lat"}, 32'(n), 32'(exp_lat));
        if (exp_lat > 1) check_val({tag, "_busy_in_ready"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [3:0]   s_op[4] = '{4'h0, 4'h8, 4'hB, 4'h7};
    logic [W-1:0] s_a[4]  = '{16'h1111, 16'hF0F0, 16'h00FF, 16'h0000};
    logic [W-1:0] s_b[4]  = '{16'h2222, 16'h0FF0, 16'h0F00, 16'hBEEF};

    initial begin
        int w, n;
        bit busy;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_outs", {14'h0, out_valid, zero, sign, overflow, div0, result},
                  {14'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed ops with latency checks
        lat_op("add_ovf", 4'h0, 16'h7FFF, 16'h0001, 1);
        lat_op("sub_zero", 4'h1, 16'h0005, 16'h0005, 1);
        lat_op("mul", 4'hC, 16'h1234, 16'h0010, 17);
        lat_op("mulhu", 4'hD, 16'hFFFF, 16'hFFFF, 17);
        lat_op("divu", 4'hE, 16'd100, 16'd7, 17);
        lat_op("remu", 4'hF, 16'd100, 16'd7, 17);
        lat_op("divu0", 4'hE, 16'd5, 16'd0, 1);
        lat_op("remu0", 4'hF, 16'd5, 16'd0, 1);
        lat_op("sra4", 4'hA, 16'd4, 16'h8000, 1);
        lat_op("sra20", 4'hA, 16'd20, 16'h8000, 1);
        lat_op("sll16", 4'h2, 16'd16, 16'hFFFF, 1);
        lat_op("sll3", 4'h2, 16'd3, 16'h1234, 1);
        lat_op("srl5", 4'h9, 16'd5, 16'hF000, 1);
        lat_op("slt", 4'h6, 16'hFFFF, 16'h0001, 1);
        lat_op("sltu", 4'h5, 16'hFFFF, 16'h0001, 1);
        lat_op("and", 4'h4, 16'hF0F0, 16'h3C3C, 1);
        lat_op("or", 4'h3, 16'hF000, 16'h000F, 1);
        lat_op("sub_ovf", 4'h1, 16'h8000, 16'h0001, 1);

        // Backpressure: result held for 5 cycles, then accept on the same cycle as release
        out_ready = 1'b0;
        issue("bp", 4'h0, 16'h1234, 16'h0001, 1'b1, w);
        wait_out(n, busy);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_hold", {10'h0, out_valid, in_ready, zero, sign, overflow, div0, result},
                      {10'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h1235});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue("bp_next", 4'h1, 16'd9, 16'd4, 1'b1, w);
        check_val("bp_next_wait", 32'(w), 32'd1);
        wait_out(n, busy);
        check_val("bp_next_lat", 32'(n), 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // Stream of 4 single-cycle ops: one per cycle in, one per cycle out
        for (int i = 0; i < 4; i++) begin
            issue($sformatf("stream%0d", i), s_op[i], s_a[i], s_b[i], 1'b1, w);
            check_val($sformatf("stream%0d_wait", i), 32'(w), 32'd1);
        end
        @(negedge clk);
        #1;
        check_val("stream_streak", 32'(streak), 32'd4);
        repeat (2) @(posedge clk);
        #1;

        // Random ops under random backpressure
        rnd_mode = 1'b1;
        for (int i = 0; i < 30; i++) begin
            logic [3:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 4'($urandom_range(0, 15));
            ra = W'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? 16'h0 : W'($urandom);
            if (ro == 4'h2 || ro == 4'h9 || ro == 4'hA) ra = W'($urandom_range(0, 20));
            issue($sformatf("rnd%0d_op%0h", i, ro), ro, ra, rb, 1'b1, w);
        end
        rnd_mode = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_val("rnd_drain", 32'(sb.size()), 32'd0);

        // Reset in the middle of a divide discards it
        issue("rst_div", 4'hE, 16'd100, 16'd7, 1'b0, w);
        repeat (8) @(posedge clk);
        #1;
        check_val("rst_div_busy", 32'(in_ready), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_outs", {14'h0, out_valid, zero, sign, overflow, div0, result},
                  {14'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_rel_in_ready", 32'(in_ready), 32'd1);
        lat_op("div_after_rst", 4'hE, 16'd9, 16'd3, 17);
        repeat (20) @(posedge clk);
        #1;
        check_val("no_phantom", 32'(out_valid), 32'd0);
        check_val("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
